// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry fetch FIFO feeding a MIPS decoder and a
// registered valid/ready output. Optional macro: DECQ_DELAY_SLOT_EN (out_ds).
module decode_queue #(
   parameter int DEPTH     = 4,
   parameter int PC_W      = 32,
   parameter bit STRICT_RI = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_instr,
   input  logic [PC_W-1:0]           in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_instr,
   output logic [PC_W-1:0]           out_pc,
   output logic [8:0]                out_ctrl,
   output logic [3:0]                out_branchid,
   output logic [2:0]                out_jid,
   output logic [3:0]                out_hilosign,
   output logic                      out_ri,
   output logic                      out_ds,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [5:0] OP_SPEC = 6'h00, OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI = 6'h0F;
   localparam logic [5:0] OP_COP0 = 6'h10;
   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
   localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09;
   localparam logic [5:0] F_SYSCALL = 6'h0C, F_BREAK = 6'h0D;
   localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11;
   localparam logic [5:0] F_MFLO = 6'h12, F_MTLO = 6'h13;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV = 6'h1A, F_DIVU = 6'h1B;
   localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23;
   localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

   localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
   localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
   localparam logic [25:0] ERET_LO = 26'h2000018;

   logic [31:0]     mem_instr [DEPTH];
   logic [PC_W-1:0] mem_pc    [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, load;
   logic [31:0]     head;
   logic [5:0]      op, funct;
   logic [4:0]      rs, rt;
   logic [8:0]      d_ctrl;
   logic [3:0]      d_br, d_hl;
   logic [2:0]      d_jid;
   logic            d_ri;

   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready && !flush;
   assign load     = (count != '0) && (!out_valid || out_ready) && !flush;
   assign head     = mem_instr[rd_ptr];
   assign op       = head[31:26];
   assign rs       = head[25:21];
   assign rt       = head[20:16];
   assign funct    = head[5:0];

   // Decode the FIFO head into the control bundle.
   always_comb begin
      d_ctrl = '0;
      d_br   = '0;
      d_jid  = '0;
      d_hl   = '0;
      d_ri   = 1'b0;
      case (op)
         OP_SPEC: begin
            case (funct)
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV,
               F_SRAV: d_ctrl = 9'b110000010;
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  d_ctrl = 9'b000000010;
                  d_hl   = 4'b1111;
               end
               F_MFHI: begin
                  d_ctrl = 9'b110000000;
                  d_hl   = 4'b1000;
               end
               F_MFLO: begin
                  d_ctrl = 9'b110000000;
                  d_hl   = 4'b0100;
               end
               F_MTHI: d_hl = 4'b0010;
               F_MTLO: d_hl = 4'b0001;
               F_JR: begin
                  d_ctrl = 9'b000000100;
                  d_jid  = 3'b010;
               end
               F_JALR: begin
                  d_ctrl = 9'b110000100;
                  d_jid  = 3'b100;
               end
               F_SYSCALL, F_BREAK: d_ctrl = '0;
               default: begin
                  d_ri = 1'b1;
                  if (!STRICT_RI) d_ctrl = 9'b110000010;
               end
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BGEZ: begin
                  d_ctrl = 9'b000100001;
                  d_br   = 4'b0011;
               end
               RT_BLTZ: begin
                  d_ctrl = 9'b000100001;
                  d_br   = 4'b0110;
               end
               RT_BGEZAL: begin
                  d_ctrl = 9'b100100001;
                  d_br   = 4'b0111;
               end
               RT_BLTZAL: begin
                  d_ctrl = 9'b100100001;
                  d_br   = 4'b1000;
               end
               default: d_ri = 1'b1;
            endcase
         end
         OP_ORI, OP_ANDI, OP_XORI, OP_LUI, OP_ADDI, OP_ADDIU,
         OP_SLTI, OP_SLTIU: d_ctrl = 9'b101000000;
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: d_ctrl = 9'b101001000;
         OP_SB, OP_SH, OP_SW: d_ctrl = 9'b001010000;
         OP_J: d_ctrl = 9'b000000100;
         OP_JAL: begin
            d_ctrl = 9'b100000100;
            d_jid  = 3'b011;
         end
         OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: begin
            d_ctrl = 9'b000100001;
            d_br   = (op == OP_BEQ)  ? 4'b0001 :
                     (op == OP_BNE)  ? 4'b0010 :
                     (op == OP_BGTZ) ? 4'b0100 : 4'b0101;
         end
         OP_COP0: begin
            case (rs)
               RS_MTC0: d_ctrl = '0;
               RS_MFC0: d_ctrl = 9'b100000000;
               default: d_ri = (head[25:0] != ERET_LO);
            endcase
         end
         default: d_ri = 1'b1;
      endcase
   end

   // Store accepted fetch pairs; storage needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

   // Pointers and occupancy; flush wins over push and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (load) rd_ptr <= rd_ptr + AW'(1);
         if (push && !load) count <= count + CW'(1);
         else if (load && !push) count <= count - CW'(1);
      end
   end

   // Output register: load the decoded head, or drop valid once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_pc       <= '0;
         out_ctrl     <= '0;
         out_branchid <= '0;
         out_jid      <= '0;
         out_hilosign <= '0;
         out_ri       <= 1'b0;
      end else if (load) begin
         out_valid    <= 1'b1;
         out_instr    <= head;
         out_pc       <= mem_pc[rd_ptr];
         out_ctrl     <= d_ctrl;
         out_branchid <= d_br;
         out_jid      <= d_jid;
         out_hilosign <= d_hl;
         out_ri       <= d_ri;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DECQ_DELAY_SLOT_EN
   logic ds_flag;

   // Tag the bundle loaded right after a branch or jump as its delay slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         ds_flag <= 1'b0;
         out_ds  <= 1'b0;
      end else if (load) begin
         out_ds  <= ds_flag;
         ds_flag <= d_ctrl[5] | d_ctrl[2];
      end
   end
`else
   assign out_ds = 1'b0;
`endif

endmodule
